sysarray_seq: RTL and testbench

//  Sequencer for a ROWS x COLS grid of systolic MAC units. It fetches one K-long dot-product pass from the weight
//  and feature buffers, then drives the west/north edges with skewed data and valid/accumulate ("end") flags.
//  It applies global ena/stall, waits for the array to drain, and reports done. Sits between the buffer

---
 rtl/sysarray_seq.sv | 198 +++++++++++++++++++
 tb/tb_sysarray_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarray_seq.sv
// sysarray_seq: fetches one K-long pass from the weight/feature buffers and drives the skewed systolic edges.
// Optional busy/stall performance counters are enabled by defining SYSSEQ_PERF_EN.
module sysarray_seq #(
  parameter int WL     = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int KMAXW  = 10,
  parameter int PIPDEP = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KMAXW-1:0]     cfg_k,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rd_en,
  output logic [KMAXW-1:0]     rd_addr,
  input  logic [ROWS*WL-1:0]   w_rdata,
  input  logic [COLS*WL-1:0]   f_rdata,
  output logic                 arr_ena,
  output logic [ROWS*WL-1:0]   arr_w,
  output logic [ROWS-1:0]      arr_wvalid,
  output logic [ROWS-1:0]      arr_wend,
  output logic [COLS*WL-1:0]   arr_f,
  output logic [COLS-1:0]      arr_fvalid,
  output logic [COLS-1:0]      arr_fend
`ifdef SYSSEQ_PERF_EN
  ,
  output logic [31:0]          perf_active,
  output logic [31:0]          perf_stall
`endif
);

  localparam int D  = ROWS + COLS + PIPDEP;
  localparam int DW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [KMAXW-1:0] k_q, k_d;
  logic [KMAXW-1:0] kmax_q, kmax_d;
  logic [KMAXW-1:0] addr_q, addr_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             err_q, err_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_end_q, rd_end_d;
  logic             issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      kmax_q   <= '0;
      addr_q   <= '0;
      dcnt_q   <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_end_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      kmax_q   <= kmax_d;
      addr_q   <= addr_d;
      dcnt_q   <= dcnt_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
      rd_end_q <= rd_end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    kmax_d  = kmax_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_k < KMAXW'(2)) begin
            err_d = 1'b1;
          end else begin
            kmax_d  = cfg_k;
            k_d     = '0;
            dcnt_d  = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!hold) begin
          issue = 1'b1;
          if (k_q == kmax_q - KMAXW'(1)) state_d = DRAIN;
          else                           k_d     = k_q + KMAXW'(1);
        end
      end
      DRAIN: begin
        if (!hold) begin
          if (dcnt_q == DW'(D - 1)) state_d = DONE;
          else                      dcnt_d  = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Read data lands one cycle after rd_en; these flags travel with it.
    rd_vld_d = hold ? rd_vld_q : issue;
    rd_end_d = hold ? rd_end_q : (issue & (k_q != '0));
    addr_d   = issue ? k_q : addr_q;
  end

  assign rd_en   = issue;
  assign rd_addr = issue ? k_q : addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign arr_ena = rst_n & ~hold;

  // Lane gi: stage-0 register followed by gi skew registers.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [WL-1:0] d_q [gi+1];
    logic [gi:0]   v_q;
    logic [gi:0]   e_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= gi; j++) d_q[j] <= '0;
        v_q <= '0;
        e_q <= '0;
      end else if (!hold) begin
        d_q[0] <= w_rdata[gi*WL +: WL];
        v_q[0] <= rd_vld_q;
        e_q[0] <= rd_end_q;
        for (int j = 1; j <= gi; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
          e_q[j] <= e_q[j-1];
        end
      end
    end
    assign arr_w[gi*WL +: WL] = d_q[gi];
    assign arr_wvalid[gi]     = v_q[gi];
    assign arr_wend[gi]       = e_q[gi];
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic [WL-1:0] d_q [gi+1];
    logic [gi:0]   v_q;
    logic [gi:0]   e_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= gi; j++) d_q[j] <= '0;
        v_q <= '0;
        e_q <= '0;
      end else if (!hold) begin
        d_q[0] <= f_rdata[gi*WL +: WL];
        v_q[0] <= rd_vld_q;
        e_q[0] <= rd_end_q;
        for (int j = 1; j <= gi; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
          e_q[j] <= e_q[j-1];
        end
      end
    end
    assign arr_f[gi*WL +: WL] = d_q[gi];
    assign arr_fvalid[gi]     = v_q[gi];
    assign arr_fend[gi]       = e_q[gi];
  end

`ifdef SYSSEQ_PERF_EN
  logic [31:0] perf_active_q, perf_stall_q;
  logic        accept;

  assign accept = (state_q == IDLE) & start & (cfg_k >= KMAXW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_active_q <= '0;
      perf_stall_q  <= '0;
    end else if (accept) begin
      perf_active_q <= '0;
      perf_stall_q  <= '0;
    end else if (busy) begin
      if (hold) begin
        if (perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        if (perf_active_q != 32'hFFFF_FFFF) perf_active_q <= perf_active_q + 32'd1;
      end
    end
  end

  assign perf_active = perf_active_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_sysarray_seq.sv
// Directed bench for sysarray_seq with a per-lane scoreboard of expected edge beats.
module tb_sysarray_seq;
  localparam int WL = 32;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KMAXW = 10;
  localparam int D = 13;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [KMAXW-1:0]    cfg_k;
  logic                hold;
  logic                busy, done, err, rd_en, arr_ena;
  logic [KMAXW-1:0]    rd_addr;
  logic [ROWS*WL-1:0]  w_rdata, arr_w;
  logic [COLS*WL-1:0]  f_rdata, arr_f;
  logic [ROWS-1:0]     arr_wvalid, arr_wend;
  logic [COLS-1:0]     arr_fvalid, arr_fend;
`ifdef SYSSEQ_PERF_EN
  logic [31:0]         perf_active, perf_stall;
`endif

  sysarray_seq #(.WL(WL), .ROWS(ROWS), .COLS(COLS), .KMAXW(KMAXW), .PIPDEP(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .hold(hold),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
    .w_rdata(w_rdata), .f_rdata(f_rdata), .arr_ena(arr_ena),
    .arr_w(arr_w), .arr_wvalid(arr_wvalid), .arr_wend(arr_wend),
    .arr_f(arr_f), .arr_fvalid(arr_fvalid), .arr_fend(arr_fend)
`ifdef SYSSEQ_PERF_EN
    , .perf_active(perf_active), .perf_stall(perf_stall)
`endif
  );

  typedef struct packed {
    logic [WL-1:0] d;
    logic          e;
  } beat_t;

  beat_t sb[4][$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t0, dc0;
  logic          mon_v, mon_e;
  logic [WL-1:0] mon_d;
  beat_t         mon_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WL-1:0] wval(input int k, input int r);
    return 32'hA000_0000 | 32'(r << 16) | 32'(k);
  endfunction

  function automatic logic [WL-1:0] fval(input int k, input int c);
    return 32'hF000_0000 | 32'(c << 16) | 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Expected beats for row 0, row 3, column 0, column 3.
  task automatic push_pass(input int k_len);
    for (int k = 0; k < k_len; k++) begin
      sb[0].push_back({wval(k, 0), k != 0});
      sb[1].push_back({wval(k, 3), k != 0});
      sb[2].push_back({fval(k, 0), k != 0});
      sb[3].push_back({fval(k, 3), k != 0});
    end
  endtask

  task automatic wait_done(input int start_cyc, input int exp_off, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 64'(done), 64'd1);
    chk(tag, 64'(cyc - start_cyc), 64'(exp_off));
  endtask

  // Buffer model: one-cycle read latency, data held while rd_en is low.
  initial begin
    w_rdata = '0;
    f_rdata = '0;
    forever begin
      @(posedge clk);
      if (rd_en === 1'b1) begin
        for (int r = 0; r < ROWS; r++) w_rdata[r*WL +: WL] <= wval(int'(rd_addr), r);
        for (int c = 0; c < COLS; c++) f_rdata[c*WL +: WL] <= fval(int'(rd_addr), c);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // A beat is consumed on a valid, non-hold cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && hold === 1'b0) begin
      for (int l = 0; l < 4; l++) begin
        case (l)
          0: begin mon_v = arr_wvalid[0]; mon_d = arr_w[0 +: WL];    mon_e = arr_wend[0]; end
          1: begin mon_v = arr_wvalid[3]; mon_d = arr_w[3*WL +: WL]; mon_e = arr_wend[3]; end
          2: begin mon_v = arr_fvalid[0]; mon_d = arr_f[0 +: WL];    mon_e = arr_fend[0]; end
          default: begin mon_v = arr_fvalid[3]; mon_d = arr_f[3*WL +: WL]; mon_e = arr_fend[3]; end
        endcase
        if (mon_v === 1'b1) begin
          if (sb[l].size() == 0) begin
            chk($sformatf("sb_extra_lane%0d", l), 64'(sb[l].size()), 64'd1);
          end else begin
            mon_b = sb[l].pop_front();
            chk($sformatf("sb_lane%0d", l), 64'({mon_d, mon_e}), 64'({mon_b.d, mon_b.e}));
          end
        end
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_k = '0;
    hold  = 1'b0;
    repeat (3) nxt();
    smp();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_valids", 64'({arr_wvalid, arr_fvalid, arr_wend, arr_fend}), 64'd0);
    chk("rst_arr_w", 64'(arr_w[63:0]), 64'd0);
    nxt();
    rst_n = 1'b1;

    // K=3, no hold: addresses, end flags, lane skew, done timing
    nxt(); start = 1'b1; cfg_k = 10'd3; push_pass(3);
    nxt(); start = 1'b0;
    smp(); t0 = cyc;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_addr0", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd0}));
    nxt(); smp();
    chk("t1_addr1", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd1}));
    chk("t1_w0_notyet", 64'(arr_wvalid[0]), 64'd0);
    nxt(); smp();
    chk("t1_addr2", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd2}));
    chk("t1_w0_k0", 64'({arr_wvalid[0], arr_wend[0]}), 64'b10);
    nxt(); smp();
    chk("t1_rd_off", 64'(rd_en), 64'd0);
    chk("t1_w0_k1", 64'({arr_wvalid[0], arr_wend[0]}), 64'b11);
    chk("t1_w3_notyet", 64'(arr_wvalid[3]), 64'd0);
    nxt(); smp();
    chk("t1_w0_k2", 64'({arr_wvalid[0], arr_wend[0]}), 64'b11);
    nxt(); smp();
    chk("t1_w0_idle", 64'(arr_wvalid[0]), 64'd0);
    chk("t1_w3_k0", 64'({arr_wvalid[3], arr_wend[3]}), 64'b10);
    chk("t1_f3_k0", 64'({arr_fvalid[3], arr_fend[3]}), 64'b10);
    wait_done(t0, 3 + D, "t1_done");
    nxt(); smp();
    chk("t1_after", 64'({done, busy, arr_wvalid, arr_fvalid}), 64'd0);

    // cfg_k below 2 is rejected with an err pulse
    nxt(); start = 1'b1; cfg_k = 10'd1;
    nxt(); start = 1'b0;
    smp();
    chk("t2_err", 64'({err, busy, rd_en}), 64'b100);
    nxt(); smp();
    chk("t2_err_end", 64'({err, busy, rd_en}), 64'b000);

    // K=4 with 5 hold cycles after address 1
    nxt(); start = 1'b1; cfg_k = 10'd4; push_pass(4);
    nxt(); start = 1'b0;
    smp(); t0 = cyc;
    chk("t3_addr0", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd0}));
    nxt(); smp();
    chk("t3_addr1", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd1}));
    for (int h = 0; h < 5; h++) begin
      nxt(); hold = 1'b1;
      smp();
      chk("t3_hold_ctl", 64'({arr_ena, rd_en, rd_addr}), 64'({1'b0, 1'b0, 10'd1}));
      chk("t3_hold_valid", 64'({arr_wvalid, arr_fvalid, arr_wend, arr_fend}), 64'({4'b0001, 4'b0001, 4'b0000, 4'b0000}));
      chk("t3_hold_w0", 64'(arr_w[0 +: WL]), 64'(wval(0, 0)));
    end
    nxt(); hold = 1'b0;
    smp();
    chk("t3_resume", 64'({arr_ena, rd_en, rd_addr}), 64'({1'b1, 1'b1, 10'd2}));
    wait_done(t0, 4 + D + 5, "t3_done");
`ifdef SYSSEQ_PERF_EN
    nxt(); smp();
    chk("t3_perf_stall", 64'(perf_stall), 64'd5);
    chk("t3_perf_active", 64'(perf_active), 64'd18);
`endif

    // start while busy is ignored
    nxt(); start = 1'b1; cfg_k = 10'd3; push_pass(3);
    nxt(); start = 1'b0;
    smp(); t0 = cyc; dc0 = done_cnt;
    nxt(); start = 1'b1; cfg_k = 10'd1;
    nxt(); start = 1'b1; cfg_k = 10'd5;
    smp();
    chk("t4_no_err", 64'(err), 64'd0);
    nxt(); start = 1'b0;
    wait_done(t0, 3 + D, "t4_done");
    repeat (10) nxt();
    smp();
    chk("t4_one_done", 64'(done_cnt - dc0), 64'd1);
    chk("t4_idle", 64'(busy), 64'd0);

    // reset during DRAIN abandons the pass
    nxt(); start = 1'b1; cfg_k = 10'd3; push_pass(3);
    nxt(); start = 1'b0;
    repeat (3) nxt();
    smp();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async", 64'({busy, done, arr_wvalid, arr_fvalid, arr_wend, arr_fend}), 64'd0);
    for (int l = 0; l < 4; l++) sb[l].delete();
    nxt(); nxt();
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (25) nxt();
    smp();
    chk("t5_no_done", 64'(done_cnt - dc0), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

    // new pass after reset, K=2
    nxt(); start = 1'b1; cfg_k = 10'd2; push_pass(2);
    nxt(); start = 1'b0;
    smp(); t0 = cyc;
    chk("t5_addr0", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd0}));
    nxt(); smp();
    chk("t5_addr1", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd1}));
    wait_done(t0, 2 + D, "t5_done");

    // hold together with start: accepted, fetch waits
    nxt(); start = 1'b1; cfg_k = 10'd2; hold = 1'b1; push_pass(2);
    nxt(); start = 1'b0;
    smp();
    chk("t6_wait", 64'({busy, rd_en}), 64'b10);
    nxt(); hold = 1'b0;
    smp(); t0 = cyc;
    chk("t6_addr0", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd0}));
    wait_done(t0, 2 + D, "t6_done");
    repeat (3) nxt();
    smp();

    for (int l = 0; l < 4; l++) chk($sformatf("sb_empty_lane%0d", l), 64'(sb[l].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
